// File: rtl/fft_job_arb.sv
// fft_job_arb: round-robin arbiter that hands a shared FFT core to one of two
// requesters and sequences the job through input, compute, output and settle.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no job; arbitrate as soon as any REQ bit is set
// ST_LOAD  | START cycle, then N_BEATS input beats with IN_RDY high
// ST_CALC  | core computing; watchdog running, waiting for DONE
// ST_DRAIN | core streaming output beats while DONE stays high
// ST_REL   | 3-cycle core settle with GNT still held
module fft_job_arb #(
    parameter int N_BEATS = 1024,
    parameter int WDOG    = 4095
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [1:0] REQ,
    input  logic       CLR_ERR,
    input  logic       DONE,
    output logic       START,
    output logic [1:0] GNT,
    output logic       OWNER,
    output logic       IN_RDY,
    output logic       OUT_VLD,
    output logic       BUSY,
    output logic       ERR
);
    localparam int WD_W = (WDOG < 1) ? 1 : $clog2(WDOG + 1);
    localparam int DR_W = $clog2(N_BEATS + 1);

    localparam logic [9:0]      BEAT_LAST = 10'(N_BEATS - 1);
    localparam logic [WD_W-1:0] WD_INIT   = WD_W'(WDOG);
    localparam logic [DR_W-1:0] DR_FULL   = DR_W'(N_BEATS);
    localparam logic [1:0]      REL_LAST  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CALC  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_REL   = 3'd4
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [9:0]      beat_cnt;
    logic [WD_W-1:0] wd_cnt;
    logic [DR_W-1:0] drain_cnt;
    logic            drain_over;
    logic [1:0]      rel_cnt;
    logic            last_srv;
    logic            win;
    logic            err_set;
    logic            enter;

    // Winner: under contention alternate away from the last served; a lone request always wins.
    always_comb begin
        win = (REQ == 2'b11) ? ~last_srv : REQ[1];
    end

    // Next-state decode and error-set detection.
    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                err_set = DONE;
                if (REQ != 2'b00) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                err_set = DONE;
                // The START cycle is not an input beat, so the count only runs after it.
                if (!START && beat_cnt == 10'd0) state_d = ST_CALC;
            end
            ST_CALC: begin
                if (DONE) begin
                    state_d = ST_DRAIN;
                end else if (wd_cnt == '0) begin
                    state_d = ST_REL;
                    err_set = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!DONE) begin
                    state_d = ST_REL;
                    err_set = drain_over || (drain_cnt != DR_FULL);
                end
            end
            ST_REL: begin
                err_set = DONE;
                if (rel_cnt == 2'd0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign enter = (state_d != state_q);

    // State register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Grant, owner and start pulse; grant drops only on the way back to IDLE.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            START <= 1'b0;
            GNT   <= 2'b00;
            OWNER <= 1'b0;
        end else begin
            START <= (state_q == ST_IDLE) && (state_d == ST_LOAD);
            if (state_d == ST_IDLE) begin
                GNT <= 2'b00;
            end else if (state_q == ST_IDLE && state_d == ST_LOAD) begin
                GNT   <= win ? 2'b10 : 2'b01;
                OWNER <= win;
            end
        end
    end

    // Input beat down-counter, loaded on LOAD entry.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            beat_cnt <= 10'd0;
        end else if (enter && state_d == ST_LOAD) begin
            beat_cnt <= BEAT_LAST;
        end else if (state_q == ST_LOAD && !START && beat_cnt != 10'd0) begin
            beat_cnt <= beat_cnt - 10'd1;
        end
    end

    // Watchdog down-counter, loaded on CALC entry; zero with DONE still low is a timeout.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wd_cnt <= '0;
        end else if (enter && state_d == ST_CALC) begin
            wd_cnt <= WD_INIT;
        end else if (state_q == ST_CALC && wd_cnt != '0) begin
            wd_cnt <= wd_cnt - WD_W'(1);
        end
    end

    // Output beat counter; the first beat arrives in CALC, and overrun is flagged rather than counted.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            drain_cnt  <= '0;
            drain_over <= 1'b0;
        end else if (enter && state_d == ST_DRAIN) begin
            drain_cnt  <= DR_W'(1);
            drain_over <= 1'b0;
        end else if (state_q == ST_DRAIN && DONE) begin
            if (drain_cnt == DR_FULL) drain_over <= 1'b1;
            else                      drain_cnt  <= drain_cnt + DR_W'(1);
        end
    end

    // Settle down-counter and round-robin pointer, both updated on REL entry.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rel_cnt  <= 2'd0;
            last_srv <= 1'b1;
        end else if (enter && state_d == ST_REL) begin
            rel_cnt  <= REL_LAST;
            last_srv <= OWNER;
        end else if (state_q == ST_REL && rel_cnt != 2'd0) begin
            rel_cnt <= rel_cnt - 2'd1;
        end
    end

    // Sticky error; a same-cycle set overrides the clear.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)        ERR <= 1'b0;
        else if (err_set) ERR <= 1'b1;
        else if (CLR_ERR) ERR <= 1'b0;
    end

    assign IN_RDY  = (state_q == ST_LOAD) && !START;
    assign OUT_VLD = DONE && ((state_q == ST_CALC) || (state_q == ST_DRAIN));
    assign BUSY    = (state_q != ST_IDLE);

endmodule

// File: doc/fft_job_arb.md
FFT_JOB_ARB -- requirements
Module: fft_job_arb

Interface
REQ-001 Parameter N_BEATS, default 1024, meaning cycles in the core's input phase and in its output phase.
REQ-002 Parameter WDOG, default 4095, meaning maximum CALC cycles before timeout.
REQ-003 Port CLK, input, 1, sole clock; all state changes on its rising edge.
REQ-004 Port RSTn, input, 1, asynchronous active-low reset.
REQ-005 Port REQ, input, 2, per-requester level job request; bit i belongs to requester i.
REQ-006 Port CLR_ERR, input, 1, synchronous clear of ERR.
REQ-007 Port DONE, input, 1, core output-phase flag, high for exactly N_BEATS cycles per job.
REQ-008 Port START, output, 1, registered one-cycle start pulse to the core.
REQ-009 Port GNT, output, 2, one-hot or zero grant vector, registered.
REQ-010 Port OWNER, output, 1, index of the current or last granted requester.
REQ-011 Port IN_RDY, output, 1, high while the owner must present an input beat.
REQ-012 Port OUT_VLD, output, 1, high while the core presents an output beat to the owner.
REQ-013 Port BUSY, output, 1, high in every state except IDLE.
REQ-014 Port ERR, output, 1, sticky protocol/timeout error flag.

Function
REQ-015 States SHALL be IDLE, LOAD, CALC, DRAIN and REL, encoded in 3 bits; unused codes SHALL return to IDLE.
REQ-016 In IDLE with REQ != 0, the block SHALL select a winner, set GNT and OWNER, pulse START for one cycle (cycle S) and enter LOAD.
REQ-017 Arbitration SHALL be round-robin: with both bits of REQ set, the requester not served last SHALL win; after reset requester 0 SHALL win.
REQ-018 With a single REQ bit set, that requester SHALL win regardless of pointer.
REQ-019 The round-robin pointer SHALL update only on entry to REL.
REQ-020 IN_RDY SHALL be high in cycles S+1 through S+N_BEATS inclusive, driven by a 10-bit beat counter, then the block SHALL enter CALC.
REQ-021 In CALC, the block SHALL wait for DONE=1, then enter DRAIN in the same cycle DONE is first sampled high.
REQ-022 OUT_VLD SHALL equal DONE while in DRAIN or while in CALC with DONE=1 (combinational), so the first output beat is not lost.
REQ-023 DRAIN SHALL count DONE-high cycles and leave for REL on the first cycle DONE is low.
REQ-024 If DONE falls with count != N_BEATS, ERR SHALL be set and the block SHALL still go to REL.
REQ-025 REL SHALL last exactly 3 cycles (core settle), with GNT held, then return to IDLE with GNT=0; the next START is no earlier than the cycle after REL ends.
REQ-026 If CALC exceeds WDOG cycles without DONE, ERR SHALL be set and the block SHALL go to REL.
REQ-027 DONE=1 in IDLE, LOAD or REL SHALL set ERR and otherwise be ignored.
REQ-028 Deasserting REQ while granted SHALL NOT abort the job; GNT SHALL persist through REL.
REQ-029 CLR_ERR SHALL clear ERR unless a set condition occurs in the same cycle, in which case set wins.
REQ-030 Counters SHALL saturate-free wrap only via explicit clear on state entry; no counter SHALL exceed its terminal value.

Reset
REQ-031 On RSTn=0, the block SHALL asynchronously force IDLE, START=0, GNT=0, OWNER=0, IN_RDY=0, OUT_VLD=0 (DONE ignored), BUSY=0, ERR=0, all counters 0, and the pointer favouring requester 0.
REQ-032 Reset mid-job SHALL drop GNT immediately; the core shares RSTn, so no recovery sequence is required.

Verification
REQ-033 Single job: REQ=01, core model DONE 1024 cycles after 2080-cycle CALC -> START at S, IN_RDY for 1024 cycles, 1024 OUT_VLD beats, GNT=01 until 3 cycles after DONE falls, ERR=0.
REQ-034 Contention: REQ=11 held over three jobs -> grants 01, 10, 01, each START separated by a full job plus 3 REL cycles.
REQ-035 Short DONE: DONE high 1000 cycles -> ERR=1 after DONE falls, REL then IDLE; CLR_ERR -> ERR=0.
REQ-036 Timeout: DONE never asserted -> ERR=1 after 4096 CALC cycles, GNT released after 3 REL cycles.
REQ-037 Reset mid-LOAD at beat 500 -> all outputs reach reset values asynchronously; next REQ=10 is granted to requester 1 with START one cycle after reset release.
